cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
- System coprocessor 0 for the P7 pipelined MIPS core.
- Sits at the M stage. Decides when an exception or interrupt is taken and raises req. The PC register then redirects fetch to the handler at 0x0000_4180.
- Saves the victim PC in EPC and supplies it back for eret.
- Holds SR, Cause, EPC and PRId, accessed by mtc0/mfc0.

Parameters:
- PRID_VALUE, 32'h2023_1109, read-only processor ID returned for register 15.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- we  input  1  mtc0 write strobe (M stage)
- addr  input  5  CP0 register number for mtc0/mfc0
- din  input  32  mtc0 write data
- dout  output  32  mfc0 read data, combinational from addr
- vpc  input  32  PC of the instruction currently in M
- bd_in  input  1  instruction in M is in a branch delay slot
- exc_code_in  input  5  pending exception code from M; 0 = none
- hw_int  input  6  external interrupt lines, level-sensitive
- eret  input  1  eret instruction in M
- req  output  1  take exception/interrupt this cycle; flushes pipeline, PC goes to 0x4180
- epc_out  output  32  current EPC value, used as eret target
- exl_out  output  1  SR.EXL

Behaviour:
- Register map:
  - 12 SR: IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - 13 Cause: BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0; not software-writable.
  - 14 EPC: bits [1:0] always 0.
  - 15 PRId: constant PRID_VALUE.
  - Any other addr reads 0; writes to it are ignored.
- Reset: SR=0, Cause=0, EPC=0. Therefore req=0, epc_out=0, exl_out=0, and dout reads 0 for addr 12/13/14.
- Request generation (combinational, same cycle as inputs):
  - int_req = (|(hw_int & SR.IM)) & SR.IE & ~SR.EXL
  - exc_req = (exc_code_in != 0) & ~SR.EXL
  - req = (int_req | exc_req) & ~rst
- Priority: interrupt over exception. On a clock edge with req=1:
  - SR.EXL <= 1
  - Cause.BD <= bd_in
  - Cause.ExcCode <= int_req ? 0 : exc_code_in
  - EPC <= bd_in ? vpc-4 : vpc, with bits [1:0] forced to 0
- Cause.IP <= hw_int on every non-reset edge, regardless of req/EXL.
- mtc0: on an edge with we=1 and req=0:
  - addr 12 stores din[15:10], din[1], din[0] into SR.
  - addr 14 stores {din[31:2],2'b00} into EPC.
  - addr 13 and 15 are ignored.
- eret: on an edge with eret=1 and req=0, SR.EXL <= 0. All other state is unchanged.
- Simultaneous events:
  - req with we: req wins, the write is discarded.
  - req with eret: req wins, EXL stays/becomes 1.
  - we to SR with eret: the SR write applies first, then EXL is forced to 0.
  - we to EPC with eret: epc_out shows the old EPC that cycle. The core must not issue both together.
- epc_out and exl_out reflect the registered values; there is no write forwarding.
- While SR.EXL=1, all requests are masked, including non-zero exc_code_in, i.e. no nesting.
- Reset asserted mid-handler clears EXL and EPC immediately on that edge. req is low during the reset cycle.
- Latency:
  - req is 0-cycle, combinational.
  - State updates become visible on the next cycle.
  - dout is combinational on current register contents.

Test Plan:
- Reset, then read addr 12/13/14/15:
  - Required: dout = 0, 0, 0, then 32'h2023_1109; req=0.
- Overflow exception:
  - Stimulus: vpc=32'h0000_3010, exc_code_in=12, bd_in=0.
  - Required: req=1 in that cycle. Next cycle EPC=32'h3010, ExcCode=12, EXL=1, BD=0. A further exc_code_in=4 gives req=0.
- Interrupt in delay slot:
  - Setup: mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1).
  - Stimulus: hw_int=6'b000001, vpc=32'h3024, bd_in=1, exc_code_in=10 in the same cycle.
  - Required: req=1. Next cycle ExcCode=0, BD=1, EPC=32'h3020, Cause.IP[10]=1.
- Masked interrupt:
  - Setup: SR=32'h0000_0400 (IE=0), hw_int=6'b000001.
  - Required: req=0, and Cause reads 32'h0000_0400.
- eret:
  - Stimulus: with EXL=1 and EPC=32'h3010, assert eret.
  - Required: epc_out=32'h3010. Next cycle EXL=0. A pending enabled interrupt then raises req.
- Conflicts:
  - Stimulus: we=1, addr=14, din=32'h0000_5007, with exc_code_in=8 in the same cycle.
  - Required: EPC=vpc, not 32'h5004.
  - Stimulus: a later standalone write of the same value.
  - Required: EPC=32'h0000_5004.

Source files
------------

// File: rtl/cp0_if.sv
// CP0 access and exception-request bundle between the M stage and coprocessor 0.
interface cp0_if;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;
    logic        exl_out;

    modport master (
        output we, addr, din, vpc, bd_in, exc_code_in, hw_int, eret,
        input  dout, req, epc_out, exl_out
    );

    modport slave (
        input  we, addr, din, vpc, bd_in, exc_code_in, hw_int, eret,
        output dout, req, epc_out, exl_out
    );
endinterface

// File: rtl/cp0_unit.sv
// MIPS coprocessor 0 (SR/Cause/EPC/PRId): decides exception/interrupt entry at M.
// req and dout are combinational; register updates are visible the next cycle.
module cp0_unit #(
    parameter logic [31:0] PRID_VALUE = 32'h2023_1109
) (
    input  logic clk,
    input  logic rst,
    cp0_if.slave bus
);
    logic [5:0]  im_q, im_d;
    logic        ie_q, ie_d;
    logic        exl_q, exl_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [29:0] epc_q, epc_d;

    logic        int_req, exc_req, req;
    logic [29:0] victim_pc;
    logic [31:0] dout_w;

    assign int_req = (|(bus.hw_int & im_q)) & ie_q & ~exl_q;
    assign exc_req = (bus.exc_code_in != 5'd0) & ~exl_q;
    assign req     = (int_req | exc_req) & ~rst;

    // EPC is word aligned, so only the word address of the victim is kept
    assign victim_pc = bus.bd_in ? (bus.vpc[31:2] - 30'd1) : bus.vpc[31:2];

    always_comb begin
        im_d  = im_q;
        ie_d  = ie_q;
        exl_d = exl_q;
        bd_d  = bd_q;
        exc_d = exc_q;
        epc_d = epc_q;
        ip_d  = bus.hw_int;
        if (req) begin
            exl_d = 1'b1;
            bd_d  = bus.bd_in;
            exc_d = int_req ? 5'd0 : bus.exc_code_in;
            epc_d = victim_pc;
        end else begin
            if (bus.we && bus.addr == 5'd12) begin
                im_d  = bus.din[15:10];
                exl_d = bus.din[1];
                ie_d  = bus.din[0];
            end
            if (bus.we && bus.addr == 5'd14) begin
                epc_d = bus.din[31:2];
            end
            // eret after a same-cycle SR write still leaves EXL cleared
            if (bus.eret) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            im_q  <= '0;
            ie_q  <= 1'b0;
            exl_q <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            ie_q  <= ie_d;
            exl_q <= exl_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    always_comb begin
        dout_w = '0;
        case (bus.addr)
            5'd12:   dout_w = {16'b0, im_q, 8'b0, exl_q, ie_q};
            5'd13:   dout_w = {bd_q, 15'b0, ip_q, 3'b0, exc_q, 2'b00};
            5'd14:   dout_w = {epc_q, 2'b00};
            5'd15:   dout_w = PRID_VALUE;
            default: dout_w = '0;
        endcase
    end

    assign bus.dout    = dout_w;
    assign bus.req     = req;
    assign bus.epc_out = {epc_q, 2'b00};
    assign bus.exl_out = exl_q;
endmodule

// File: tb/tb_cp0_unit.sv
// Directed and random checks of cp0_unit against an architectural register model.
module tb_cp0_unit;
    localparam logic [31:0] PRID = 32'h2023_1109;

    logic clk = 1'b0;
    logic rst;
    cp0_if bus ();

    cp0_unit #(.PRID_VALUE(PRID)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // architectural view: the values software would read from SR, Cause, EPC
    logic [31:0] m_sr, m_cause, m_epc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic m_int_pending();
        return ((bus.hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return !rst && !m_sr[1] && (m_int_pending() || bus.exc_code_in != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    // check outputs against the model, clock one edge, advance the model
    task automatic cyc();
        logic r, ip;
        #1;
        r  = m_req();
        ip = m_int_pending();
        chk("req", 32'(bus.req), 32'(r));
        chk("dout", bus.dout, m_read(bus.addr));
        chk("epc_out", bus.epc_out, m_epc);
        chk("exl_out", 32'(bus.exl_out), 32'(m_sr[1]));
        @(posedge clk);
        if (rst) begin
            m_sr = 0; m_cause = 0; m_epc = 0;
        end else begin
            if (r) begin
                m_sr    = m_sr | 32'd2;
                m_cause = {bus.bd_in, 31'b0} | (ip ? 32'd0 : ({27'b0, bus.exc_code_in} << 2));
                m_epc   = (bus.bd_in ? bus.vpc - 32'd4 : bus.vpc) & 32'hFFFF_FFFC;
            end else begin
                if (bus.we && bus.addr == 5'd12) m_sr = bus.din & 32'h0000_FC03;
                if (bus.we && bus.addr == 5'd14) m_epc = bus.din & 32'hFFFF_FFFC;
                if (bus.eret) m_sr = m_sr & ~32'd2;
            end
            m_cause = (m_cause & ~32'h0000_FC00) | ({26'b0, bus.hw_int} << 10);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.we = 0; bus.addr = 0; bus.din = 0; bus.vpc = 0; bus.bd_in = 0;
        bus.exc_code_in = 0; bus.hw_int = 0; bus.eret = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_sr = 0; m_cause = 0; m_epc = 0;

        // req must stay low while reset is held, even with a pending exception
        bus.exc_code_in = 5'd12;
        #1 chk("req_in_reset", 32'(bus.req), 32'd0);
        cyc();
        rst = 0;
        idle();

        bus.addr = 5'd12; #1 chk("rst_sr", bus.dout, 32'd0);
        bus.addr = 5'd13; #1 chk("rst_cause", bus.dout, 32'd0);
        bus.addr = 5'd14; #1 chk("rst_epc", bus.dout, 32'd0);
        bus.addr = 5'd15; #1 chk("prid", bus.dout, 32'h2023_1109);
        cyc();

        // overflow exception
        bus.vpc = 32'h0000_3010; bus.exc_code_in = 5'd12;
        #1 chk("ovf_req", 32'(bus.req), 32'd1);
        cyc();
        bus.exc_code_in = 0;
        bus.addr = 5'd14; #1 chk("ovf_epc", bus.dout, 32'h0000_3010);
        bus.addr = 5'd13; #1 chk("ovf_cause", bus.dout, 32'h0000_0030);
        chk("ovf_exl", 32'(bus.exl_out), 32'd1);
        bus.exc_code_in = 5'd4;
        #1 chk("ovf_no_nest", 32'(bus.req), 32'd0);
        cyc();

        bus.exc_code_in = 0; bus.eret = 1;
        #1 chk("eret_epc", bus.epc_out, 32'h0000_3010);
        cyc();
        bus.eret = 0;
        #1 chk("eret_exl", 32'(bus.exl_out), 32'd0);

        // interrupt beats a same-cycle exception, victim in a delay slot
        bus.we = 1; bus.addr = 5'd12; bus.din = 32'h0000_0401;
        cyc();
        bus.we = 0;
        bus.hw_int = 6'b000001; bus.vpc = 32'h0000_3024; bus.bd_in = 1; bus.exc_code_in = 5'd10;
        #1 chk("ds_int_req", 32'(bus.req), 32'd1);
        cyc();
        bus.bd_in = 0; bus.exc_code_in = 0; bus.vpc = 32'h0000_3030;
        bus.addr = 5'd13; #1 chk("ds_cause", bus.dout, 32'h8000_0400);
        bus.addr = 5'd14; #1 chk("ds_epc", bus.dout, 32'h0000_3020);
        chk("ds_masked_by_exl", 32'(bus.req), 32'd0);

        bus.eret = 1;
        cyc();
        bus.eret = 0;
        #1 chk("pending_int_after_eret", 32'(bus.req), 32'd1);
        cyc();

        // SR write together with eret: write lands, EXL ends up clear
        bus.we = 1; bus.addr = 5'd12; bus.din = 32'h0000_0400; bus.eret = 1;
        cyc();
        bus.we = 0; bus.eret = 0;
        chk("sr_eret_exl", 32'(bus.exl_out), 32'd0);
        chk("masked_req", 32'(bus.req), 32'd0);
        bus.addr = 5'd13; #1 chk("masked_cause", bus.dout, 32'h0000_0400);
        bus.addr = 5'd12; #1 chk("masked_sr", bus.dout, 32'h0000_0400);

        // exception wins over a same-cycle EPC write
        bus.vpc = 32'h0000_3040; bus.we = 1; bus.addr = 5'd14; bus.din = 32'h0000_5007;
        bus.exc_code_in = 5'd8;
        #1 chk("conflict_req", 32'(bus.req), 32'd1);
        cyc();
        bus.we = 0; bus.exc_code_in = 0;
        bus.addr = 5'd14; #1 chk("conflict_epc", bus.dout, 32'h0000_3040);
        bus.we = 1; bus.din = 32'h0000_5007;
        cyc();
        bus.we = 0;
        #1 chk("standalone_epc", bus.epc_out, 32'h0000_5004);

        // writes to Cause and PRId have no effect
        bus.we = 1; bus.addr = 5'd13; bus.din = 32'hFFFF_FFFF; cyc();
        bus.addr = 5'd15; cyc();
        bus.we = 0;

        // reset in the middle of a handler
        rst = 1; cyc(); rst = 0;
        chk("midrst_exl", 32'(bus.exl_out), 32'd0);
        chk("midrst_epc", bus.epc_out, 32'd0);

        for (int i = 0; i < 600; i++) begin
            rst             = ($urandom % 50) == 0;
            bus.we          = ($urandom % 4) == 0;
            bus.addr        = ($urandom % 2) ? 5'(12 + ($urandom % 4)) : 5'($urandom);
            bus.din         = $urandom;
            bus.vpc         = $urandom;
            bus.bd_in       = 1'($urandom);
            bus.exc_code_in = (($urandom % 4) == 0) ? 5'($urandom) : 5'd0;
            bus.hw_int      = 6'($urandom);
            bus.eret        = ($urandom % 5) == 0;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
